// File: rtl/bch_31_chien_if.sv
// Handshake and result bundle between the BCH(31) Chien search and its neighbours.
interface bch_31_chien_if;
  logic        start;
  logic [4:0]  lambda1;
  logic [4:0]  lambda2;
  logic        busy;
  logic        done;
  logic [30:0] err_mask;
  logic [1:0]  err_count;
  logic        fail;

  modport master (
    output start, lambda1, lambda2,
    input  busy, done, err_mask, err_count, fail
  );

  modport slave (
    input  start, lambda1, lambda2,
    output busy, done, err_mask, err_count, fail
  );
endinterface

// File: rtl/bch_31_chien.sv
// Chien search for BCH(31) t=2: evaluates 1 + l1*x + l2*x^2 at x = alpha^-i, i = 0..30,
// over GF(2^5) with x^5+x^2+1, producing the error mask, root count and failure flag.
//
// state  | meaning
// IDLE   | waiting for start; results of the last search held
// SEARCH | one codeword position tested per cycle, pos = 0..30
// FINISH | root count compared against degree; done pulse follows
module bch_31_chien #(
  parameter int N = 31,
  parameter int M = 5
) (
  input  logic          clk,
  input  logic          rst,
  bch_31_chien_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FINISH
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [M-1:0]   t1;
  logic [M-1:0]   t2;
  logic [4:0]     pos;
  logic [1:0]     deg;
  logic [1:0]     cnt;
  logic [N-1:0]   mask;
  logic           done_q;
  logic           fail_q;
  logic           hit;

  // alpha^-1 = alpha^4 + alpha, so a shift right folds bit 0 back into bits 4 and 1
  function automatic logic [M-1:0] mul_inv(input logic [M-1:0] a);
    return (a >> 1) ^ (a[0] ? 5'b10010 : 5'b00000);
  endfunction

  assign hit = ((t1 ^ t2) == 5'b00001);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (pos == 5'(N - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      t1     <= '0;
      t2     <= '0;
      pos    <= '0;
      deg    <= '0;
      cnt    <= '0;
      mask   <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            t1     <= bus.lambda1;
            t2     <= bus.lambda2;
            pos    <= '0;
            deg    <= (bus.lambda2 != '0) ? 2'd2 : ((bus.lambda1 != '0) ? 2'd1 : 2'd0);
            cnt    <= '0;
            mask   <= '0;
            fail_q <= 1'b0;
          end
        end
        SEARCH: begin
          if (hit) begin
            mask[pos] <= 1'b1;
            if (cnt != 2'd3) cnt <= cnt + 2'd1;
          end
          t1  <= mul_inv(t1);
          t2  <= mul_inv(mul_inv(t2));
          pos <= pos + 5'd1;
        end
        FINISH: begin
          done_q <= 1'b1;
          fail_q <= (cnt != deg);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == SEARCH);
  assign bus.done      = done_q;
  assign bus.err_mask  = mask;
  assign bus.err_count = cnt;
  assign bus.fail      = fail_q;

endmodule
